// File: rtl/csa_accum_if.sv
// Operand stream and result handshake bundle for the carry-save accumulator.
// The slave side is the accumulator; the master side feeds operands and drains results.
interface csa_accum_if #(
    parameter int WIDTH = 18,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/csa_accum.sv
// Group accumulator: operands are summed in carry-save form (no carry chain per step)
// and resolved by a single carry-propagate add once the last operand of a group arrives.
module csa_accum #(
    parameter int WIDTH = 18,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    csa_accum_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_outSum;
    logic [CNT_W-1:0] r_outCount;
    logic             r_live;

    logic             w_inReady;
    logic             w_outValid;
    logic             w_accept;
    logic             w_release;
    logic             w_countFull;
    logic [WIDTH-1:0] w_csaSum;
    logic [WIDTH-2:0] w_csaMaj;
    logic [WIDTH-1:0] w_csaCarry;
    logic [WIDTH-1:0] w_resolved;

    assign w_accept    = bus.in_valid & w_inReady;
    assign w_release   = w_outValid & bus.out_ready;
    assign w_countFull = &r_count;

    // 3:2 compression per bit; the majority out of the top bit falls off the word.
    assign w_csaSum   = r_sum ^ r_carry ^ bus.in_data;
    assign w_csaMaj   = (r_sum[WIDTH-2:0] & r_carry[WIDTH-2:0])
                      | (r_sum[WIDTH-2:0] & bus.in_data[WIDTH-2:0])
                      | (r_carry[WIDTH-2:0] & bus.in_data[WIDTH-2:0]);
    assign w_csaCarry = {w_csaMaj, 1'b0};
    assign w_resolved = r_sum + r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_nextState = bus.in_last ? RESOLVE : ACCUM;
                end
            end
            RESOLVE: w_nextState = DONE;
            DONE: begin
                if (w_release) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // r_live holds off in_ready until the first edge after reset is released.
    always_comb begin
        w_inReady  = 1'b0;
        w_outValid = 1'b0;
        case (r_state)
            IDLE, ACCUM: w_inReady  = r_live;
            DONE:        w_outValid = 1'b1;
            default: begin
                w_inReady  = 1'b0;
                w_outValid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_count <= '0;
        end else if (w_release) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_sum   <= w_csaSum;
            r_carry <= w_csaCarry;
            if (!w_countFull) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Results are captured once in RESOLVE and then held untouched through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outSum   <= '0;
            r_outCount <= '0;
        end else if (r_state == RESOLVE) begin
            r_outSum   <= w_resolved;
            r_outCount <= r_count;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.out_sum   = r_outSum;
    assign bus.out_count = r_outCount;

endmodule

// File: doc/csa_accum.md
CSA_ACCUM -- requirements
Module: csa_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 18, the operand/result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the operand counter.
REQ-003 The block SHALL have port clk  input  1  the single clock, all state rising-edge triggered.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  operand present on in_data.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an operand this cycle.
REQ-007 The block SHALL have port in_data  input  WIDTH  operand to add.
REQ-008 The block SHALL have port in_last  input  1  qualifies the final operand of a group.
REQ-009 The block SHALL have port out_valid  output  1  out_sum and out_count are valid.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 The block SHALL have port out_sum  output  WIDTH  resolved sum of the group, modulo 2^WIDTH.
REQ-012 The block SHALL have port out_count  output  CNT_W  number of operands in the group, saturating.

Function
REQ-013 The block SHALL hold the running total in carry-save form: sum register S[WIDTH-1:0] and carry register C[WIDTH-1:0], C stored already shifted left by one.
REQ-014 On each accepted operand D (in_valid & in_ready), the block SHALL update S <= S ^ C ^ D and C <= {maj(S,C,D)[WIDTH-2:0], 1'b0}, where maj is the bitwise majority; the carry out of bit WIDTH-1 SHALL be discarded.
REQ-015 The accumulate step SHALL contain no carry-propagate path; it is WIDTH independent 3:2 full-adder cells.
REQ-016 The state machine SHALL have states IDLE, ACCUM, RESOLVE, DONE.
REQ-017 IDLE: S = 0, C = 0, count = 0, in_ready = 1; an accepted operand without in_last SHALL move to ACCUM; with in_last it SHALL move to RESOLVE.
REQ-018 ACCUM: in_ready = 1; an accepted operand with in_last SHALL move to RESOLVE; without in_last it SHALL remain in ACCUM.
REQ-019 in_last SHALL be ignored when in_valid is 0.
REQ-020 RESOLVE: in_ready = 0; the block SHALL register out_sum <= (S + C) mod 2^WIDTH and out_count <= count, and move to DONE after exactly one cycle.
REQ-021 DONE: out_valid = 1 and in_ready = 0; out_sum and out_count SHALL stay stable until out_valid & out_ready.
REQ-022 On out_valid & out_ready, the block SHALL clear S, C and count and return to IDLE the next cycle.
REQ-023 Latency from acceptance of the in_last operand to out_valid SHALL be 2 cycles.
REQ-024 A new group SHALL be accepted no earlier than the cycle after the handshake in REQ-022.
REQ-025 count SHALL increment by 1 per accepted operand and SHALL saturate at 2^CNT_W-1.
REQ-026 out_valid SHALL be 0 in IDLE, ACCUM and RESOLVE.

Reset
REQ-027 When rst_n is 0, the block SHALL immediately enter IDLE with S = 0, C = 0, count = 0, out_sum = 0, out_count = 0, out_valid = 0.
REQ-028 in_ready SHALL be 0 while rst_n is 0 and SHALL be 1 from the first clock edge after rst_n goes high.
REQ-029 Reset asserted in ACCUM, RESOLVE or DONE SHALL discard the partial group and any unread result.

Verification
REQ-030 The bench SHALL drive operands 3, 5, 7 (in_last on 7) with out_ready=1 -> out_valid 2 cycles after 7 is accepted, out_sum=15, out_count=3.
REQ-031 The bench SHALL drive (WIDTH=18) 0x3FFFF then 0x00001 with in_last -> out_sum=0x00000, out_count=2.
REQ-032 The bench SHALL drive a single operand 0x12345 with in_last from IDLE -> out_sum=0x12345, out_count=1.
REQ-033 The bench SHALL drive 1, 2 (in_last) with out_ready=0 for 5 cycles -> out_valid held, out_sum=3 stable, in_ready=0, and in_valid operands offered during this time are ignored; then out_ready=1 -> IDLE, next group 4 (in_last) gives out_sum=4.
REQ-034 The bench SHALL drive 10, 20, pulse rst_n low mid-group, then 6 (in_last) -> out_sum=6, out_count=1.
REQ-035 The bench SHALL drive (CNT_W=8) 300 operands of value 1 -> out_count=255, out_sum=300.
